// File: rtl/trap_unit.sv
// Machine-mode trap and CSR unit: privilege, mstatus/mie/mtvec/mepc/mcause/mscratch, trap entry and mret sequencing.
// Optional machine timer interrupt path is compiled in when TRAP_INTERRUPT_EN is defined.
module trap_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            instrValid,
    input  logic [2:0]      exceptSignal,
    input  logic            trapReturn,
    input  logic            csrWriteEnable,
    input  logic [2:0]      csrFunct3,
    input  logic [11:0]     csrAddr,
    input  logic [XLEN-1:0] csrOperand,
    input  logic [XLEN-1:0] pc,
    input  logic            irq,
    output logic [XLEN-1:0] csrRdata,
    output logic [1:0]      privMode,
    output logic            pcRedirect,
    output logic [XLEN-1:0] redirectPc,
    output logic            flush,
    output logic            trapStall
);
    localparam logic [1:0]  PRIV_M     = 2'b11;
    localparam logic [1:0]  PRIV_U     = 2'b00;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;

    typedef enum logic [1:0] {S_RUN, S_ENTER, S_RETURN} state_e;

    state_e          state_q;
    logic [1:0]      priv_q, mpp_q;
    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mscratch_q;
    logic            redirect_q;

    logic            in_run, irq_take, illegal, ecall, ebreak, trap_take, ret_take, csr_we;
    logic [XLEN-1:0] cause_d, wdata_d;

    assign in_run = (state_q == S_RUN);

`ifdef TRAP_INTERRUPT_EN
    logic mtie_q;
    assign irq_take = in_run && instrValid && irq && mie_q && mtie_q;
    logic unused_ok;
    assign unused_ok = ^{csrFunct3[2], pc[1:0]};
`else
    assign irq_take = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{csrFunct3[2], pc[1:0], irq};
`endif

    // mret outside M mode is treated as an illegal instruction
    assign illegal   = in_run && instrValid && (exceptSignal[2] || (trapReturn && priv_q != PRIV_M));
    assign ecall     = in_run && instrValid && exceptSignal[1];
    assign ebreak    = in_run && instrValid && exceptSignal[0];
    assign trap_take = irq_take || illegal || ecall || ebreak;
    assign ret_take  = in_run && instrValid && trapReturn && (priv_q == PRIV_M) && !trap_take;

    always_comb begin
        cause_d = XLEN'(3);
        if (irq_take)     cause_d = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
        else if (illegal) cause_d = XLEN'(2);
        else if (ecall)   cause_d = (priv_q == PRIV_M) ? XLEN'(11) : XLEN'(8);
    end

    always_comb begin
        csrRdata = '0;
        case (csrAddr)
            A_MSTATUS: begin
                csrRdata[3]     = mie_q;
                csrRdata[7]     = mpie_q;
                csrRdata[12:11] = mpp_q;
            end
            A_MIE: begin
`ifdef TRAP_INTERRUPT_EN
                csrRdata[7] = mtie_q;
`endif
            end
            A_MTVEC:    csrRdata = mtvec_q;
            A_MSCRATCH: csrRdata = mscratch_q;
            A_MEPC:     csrRdata = mepc_q;
            A_MCAUSE:   csrRdata = mcause_q;
            default:    ;
        endcase
    end

    always_comb begin
        case (csrFunct3[1:0])
            2'b10:   wdata_d = csrRdata | csrOperand;
            2'b11:   wdata_d = csrRdata & ~csrOperand;
            default: wdata_d = csrOperand;
        endcase
    end

    // set/clear forms with a zero operand are pure reads
    assign csr_we = in_run && instrValid && csrWriteEnable && !trap_take &&
                    ((csrFunct3[1:0] == 2'b01) || ((csrFunct3[1:0] != 2'b00) && (csrOperand != '0)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_RUN;
            priv_q     <= PRIV_M;
            mpp_q      <= PRIV_U;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            redirect_q <= 1'b0;
`ifdef TRAP_INTERRUPT_EN
            mtie_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (trap_take) begin
                        mepc_q     <= {pc[XLEN-1:2], 2'b00};
                        mcause_q   <= cause_d;
                        state_q    <= S_ENTER;
                        redirect_q <= 1'b1;
                    end else begin
                        if (csr_we) begin
                            case (csrAddr)
                                A_MSTATUS: begin
                                    mie_q  <= wdata_d[3];
                                    mpie_q <= wdata_d[7];
                                    mpp_q  <= (wdata_d[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
                                end
`ifdef TRAP_INTERRUPT_EN
                                A_MIE:      mtie_q     <= wdata_d[7];
`endif
                                A_MTVEC:    mtvec_q    <= {wdata_d[XLEN-1:2], 2'b00};
                                A_MSCRATCH: mscratch_q <= wdata_d;
                                A_MEPC:     mepc_q     <= {wdata_d[XLEN-1:2], 2'b00};
                                A_MCAUSE:   mcause_q   <= wdata_d;
                                default:    ;
                            endcase
                        end
                        if (ret_take) begin
                            state_q    <= S_RETURN;
                            redirect_q <= 1'b1;
                        end
                    end
                end
                S_ENTER: begin
                    mpp_q      <= priv_q;
                    mpie_q     <= mie_q;
                    mie_q      <= 1'b0;
                    priv_q     <= PRIV_M;
                    state_q    <= S_RUN;
                    redirect_q <= 1'b0;
                end
                S_RETURN: begin
                    priv_q     <= mpp_q;
                    mpp_q      <= PRIV_U;
                    mie_q      <= mpie_q;
                    mpie_q     <= 1'b1;
                    state_q    <= S_RUN;
                    redirect_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_RUN;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    assign privMode   = priv_q;
    assign pcRedirect = redirect_q;
    assign flush      = redirect_q;
    assign trapStall  = redirect_q;
    assign redirectPc = (state_q == S_RETURN) ? mepc_q : mtvec_q;

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios plus randomized instruction stream
// compared against an architectural model of the machine trap CSRs.
module tb_trap_unit;
    localparam int          XLEN    = 64;
    localparam logic [63:0] MTV_RST = 64'h0000_0000_0000_0400;
`ifdef TRAP_INTERRUPT_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        instrValid = 1'b0, trapReturn = 1'b0, csrWriteEnable = 1'b0, irq = 1'b0;
    logic [2:0]  exceptSignal = '0, csrFunct3 = '0;
    logic [11:0] csrAddr = '0;
    logic [63:0] csrOperand = '0, pc = '0;
    logic [63:0] csrRdata, redirectPc;
    logic [1:0]  privMode;
    logic        pcRedirect, flush, trapStall;

    trap_unit #(.XLEN(XLEN), .MTVEC_RESET(MTV_RST)) dut (
        .clk(clk), .reset_n(reset_n), .instrValid(instrValid), .exceptSignal(exceptSignal),
        .trapReturn(trapReturn), .csrWriteEnable(csrWriteEnable), .csrFunct3(csrFunct3),
        .csrAddr(csrAddr), .csrOperand(csrOperand), .pc(pc), .irq(irq),
        .csrRdata(csrRdata), .privMode(privMode), .pcRedirect(pcRedirect),
        .redirectPc(redirectPc), .flush(flush), .trapStall(trapStall)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Architectural model state
    logic [1:0]  m_priv, m_mpp;
    logic        m_mie, m_mpie, m_mtie;
    logic [63:0] m_mtvec, m_mepc, m_mcause, m_mscratch;

    // Per-instruction observations and expectations
    logic [63:0] obs_rdata, exp_rdata, obs_rpc, exp_rpc;
    logic        obs_redir, exp_redir, obs_flush, obs_stall;
    logic [2:0]  obs_post;
    logic [1:0]  obs_priv;

    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0, 12'hF14};

    task automatic m_reset();
        m_priv = 2'b11; m_mpp = 2'b00; m_mie = 1'b0; m_mpie = 1'b0; m_mtie = 1'b0;
        m_mtvec = MTV_RST; m_mepc = '0; m_mcause = '0; m_mscratch = '0;
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {51'b0, m_mpp, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h304: return HAS_IRQ ? {56'b0, m_mtie, 7'b0} : 64'd0;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 64'd0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [63:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; m_mpp = v[12:11]; end
            12'h304: if (HAS_IRQ) m_mtie = v[7];
            12'h305: m_mtvec = v & ~64'h3;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~64'h3;
            12'h342: m_mcause = v;
            default: ;
        endcase
    endtask

    task automatic idle();
        instrValid = 1'b0; exceptSignal = '0; trapReturn = 1'b0; csrWriteEnable = 1'b0;
        csrFunct3 = '0; csrOperand = '0; irq = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a, output logic [63:0] v);
        instrValid = 1'b0; csrAddr = a; #1; v = csrRdata;
    endtask

    // Present one instruction in cycle N, walk through ENTER/RETURN if taken, update the model.
    task automatic exec(input logic v, input logic [2:0] ex, input logic mr, input logic cwe,
                        input logic [2:0] f3, input logic [11:0] a, input logic [63:0] op,
                        input logic [63:0] p, input logic ir);
        logic intr, ill, trap, ret, wr;
        logic [63:0] old, nv;
        instrValid = v; exceptSignal = ex; trapReturn = mr; csrWriteEnable = cwe;
        csrFunct3 = f3; csrAddr = a; csrOperand = op; pc = p; irq = ir;
        #1;
        obs_rdata = csrRdata;
        old  = m_read(a);
        exp_rdata = old;
        intr = HAS_IRQ && v && ir && m_mie && m_mtie;
        ill  = v && (ex[2] || (mr && m_priv != 2'b11));
        trap = intr || ill || (v && ex[1]) || (v && ex[0]);
        ret  = !trap && v && mr && (m_priv == 2'b11);
        wr   = !trap && v && cwe && ((f3[1:0] == 2'b01) || ((f3[1:0] != 2'b00) && (op != 64'd0)));
        exp_redir = trap || ret;
        if (trap) begin
            m_mepc   = p & ~64'h3;
            m_mcause = intr ? 64'h8000_0000_0000_0007 : ill ? 64'd2 :
                       (v && ex[1]) ? ((m_priv == 2'b11) ? 64'd11 : 64'd8) : 64'd3;
            exp_rpc  = m_mtvec;
        end else begin
            if (wr) begin
                nv = (f3[1:0] == 2'b10) ? (old | op) : (f3[1:0] == 2'b11) ? (old & ~op) : op;
                m_write(a, nv);
            end
            exp_rpc = m_mepc;
        end
        @(posedge clk); #1;
        obs_redir = pcRedirect; obs_rpc = redirectPc; obs_flush = flush; obs_stall = trapStall;
        if (exp_redir) begin
            // garbage during ENTER/RETURN must be ignored
            instrValid = 1'b1; exceptSignal = 3'($urandom); trapReturn = 1'($urandom);
            csrWriteEnable = 1'b1; csrFunct3 = 3'b001; csrAddr = 12'h340;
            csrOperand = {$urandom, $urandom}; irq = 1'($urandom);
            @(posedge clk); #1;
            if (trap) begin
                m_mpp = m_priv; m_mpie = m_mie; m_mie = 1'b0; m_priv = 2'b11;
            end else begin
                m_priv = m_mpp; m_mpp = 2'b00; m_mie = m_mpie; m_mpie = 1'b1;
            end
        end
        obs_post = {pcRedirect, flush, trapStall};
        obs_priv = privMode;
        idle();
    endtask

    task automatic csrw(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] op);
        exec(1'b1, 3'b000, 1'b0, 1'b1, f3, a, op, 64'h100, 1'b0);
    endtask

    task automatic test_reset();
        logic [63:0] v;
        idle(); reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1; m_reset();
        peek(12'h305, v);
        checks++; if (v !== MTV_RST) begin errors++; $display("FAIL reset_mtvec got %h want %h", v, MTV_RST); end
        checks++; if (privMode !== 2'b11) begin errors++; $display("FAIL reset_priv got %b want 11", privMode); end
        checks++; if ({pcRedirect, flush, trapStall} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl got %b want 000", {pcRedirect, flush, trapStall}); end
        for (int i = 0; i < 8; i++) begin
            if (addrs[i] == 12'h305) continue;
            peek(addrs[i], v);
            checks++; if (v !== 64'd0) begin errors++; $display("FAIL reset_csr_%h got %h want 0", addrs[i], v); end
        end
    endtask

    task automatic test_csr_rw();
        logic [63:0] v;
        csrw(3'b001, 12'h305, 64'h8000_0103);
        checks++; if (obs_rdata !== MTV_RST) begin errors++; $display("FAIL csrrw_old got %h want %h", obs_rdata, MTV_RST); end
        peek(12'h305, v);
        checks++; if (v !== 64'h8000_0100) begin errors++; $display("FAIL mtvec_rw got %h want 80000100", v); end
        csrw(3'b001, 12'h340, 64'hDEAD);
        csrw(3'b010, 12'h340, 64'h0);
        peek(12'h340, v);
        checks++; if (v !== 64'hDEAD) begin errors++; $display("FAIL rs_zero got %h want dead", v); end
        csrw(3'b011, 12'h340, 64'hFF);
        peek(12'h340, v);
        checks++; if (v !== 64'hDE00) begin errors++; $display("FAIL rc got %h want de00", v); end
        csrw(3'b110, 12'h340, 64'h5);
        peek(12'h340, v);
        checks++; if (v !== 64'hDE05) begin errors++; $display("FAIL rsi got %h want de05", v); end
        csrw(3'b001, 12'h7C0, 64'h55);
        peek(12'h7C0, v);
        checks++; if (v !== 64'd0) begin errors++; $display("FAIL unmapped got %h want 0", v); end
    endtask

    task automatic test_u_ecall();
        logic [63:0] v;
        csrw(3'b001, 12'h341, 64'h3000);
        exec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 12'h000, 64'd0, 64'h200, 1'b0);
        checks++; if (obs_rpc !== 64'h3000 || obs_redir !== 1'b1) begin errors++;
            $display("FAIL mret_to_u got redir=%b pc=%h want redir=1 pc=3000", obs_redir, obs_rpc); end
        checks++; if (obs_priv !== 2'b00) begin errors++; $display("FAIL mret_priv got %b want 00", obs_priv); end
        exec(1'b1, 3'b010, 1'b0, 1'b0, 3'b000, 12'h000, 64'd0, 64'h1000, 1'b0);
        checks++; if ({obs_redir, obs_flush, obs_stall} !== 3'b111 || obs_rpc !== 64'h8000_0100) begin errors++;
            $display("FAIL ecall_enter got ctrl=%b pc=%h want ctrl=111 pc=80000100", {obs_redir, obs_flush, obs_stall}, obs_rpc); end
        checks++; if (obs_post !== 3'b000) begin errors++; $display("FAIL ecall_post got %b want 000", obs_post); end
        peek(12'h341, v);
        checks++; if (v !== 64'h1000) begin errors++; $display("FAIL ecall_mepc got %h want 1000", v); end
        peek(12'h342, v);
        checks++; if (v !== 64'd8) begin errors++; $display("FAIL ecall_u_cause got %h want 8", v); end
        peek(12'h300, v);
        checks++; if (v[12:11] !== 2'b00 || privMode !== 2'b11) begin errors++;
            $display("FAIL ecall_priv got mpp=%b priv=%b want mpp=00 priv=11", v[12:11], privMode); end
    endtask

    task automatic test_priority();
        logic [63:0] v;
        exec(1'b1, 3'b101, 1'b0, 1'b1, 3'b001, 12'h340, 64'h1234, 64'h1100, 1'b0);
        peek(12'h342, v);
        checks++; if (v !== 64'd2) begin errors++; $display("FAIL ill_prio_cause got %h want 2", v); end
        peek(12'h340, v);
        checks++; if (v !== 64'hDE05) begin errors++; $display("FAIL ill_suppress_wr got %h want de05", v); end
        csrw(3'b011, 12'h300, 64'h1800);
        exec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 12'h000, 64'd0, 64'h1104, 1'b0);
        checks++; if (obs_priv !== 2'b00) begin errors++; $display("FAIL to_u got %b want 00", obs_priv); end
        exec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 12'h000, 64'd0, 64'h1200, 1'b0);
        peek(12'h342, v);
        checks++; if (v !== 64'd2 || obs_rpc !== 64'h8000_0100) begin errors++;
            $display("FAIL mret_in_u got cause=%h pc=%h want cause=2 pc=80000100", v, obs_rpc); end
        peek(12'h341, v);
        checks++; if (v !== 64'h1200 || obs_priv !== 2'b11) begin errors++;
            $display("FAIL mret_in_u_mepc got %h priv=%b want 1200 priv=11", v, obs_priv); end
    endtask

    task automatic test_mret();
        logic [63:0] v;
        csrw(3'b001, 12'h341, 64'h2000);
        csrw(3'b001, 12'h300, 64'h1880);
        exec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 12'h000, 64'd0, 64'h300, 1'b0);
        checks++; if (obs_rpc !== 64'h2000 || {obs_redir, obs_flush, obs_stall} !== 3'b111) begin errors++;
            $display("FAIL mret_redirect got pc=%h ctrl=%b want pc=2000 ctrl=111", obs_rpc, {obs_redir, obs_flush, obs_stall}); end
        peek(12'h300, v);
        checks++; if (v !== 64'h88) begin errors++; $display("FAIL mret_mstatus got %h want 88", v); end
        checks++; if (obs_priv !== 2'b11) begin errors++; $display("FAIL mret_priv got %b want 11", obs_priv); end
    endtask

    task automatic test_interrupt();
        logic [63:0] v;
        logic [63:0] want;
        want = HAS_IRQ ? 64'h8000_0000_0000_0007 : 64'd11;
        csrw(3'b010, 12'h304, 64'h80);
        exec(1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 12'h000, 64'd0, 64'h3FFC, 1'b1);
        checks++; if (obs_redir !== 1'b0) begin errors++; $display("FAIL irq_needs_valid got %b want 0", obs_redir); end
        exec(1'b1, 3'b010, 1'b0, 1'b0, 3'b000, 12'h000, 64'd0, 64'h4000, 1'b1);
        peek(12'h342, v);
        checks++; if (v !== want) begin errors++; $display("FAIL irq_cause got %h want %h", v, want); end
        peek(12'h341, v);
        checks++; if (v !== 64'h4000) begin errors++; $display("FAIL irq_mepc got %h want 4000", v); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        exec(1'b1, 3'b010, 1'b0, 1'b0, 3'b000, 12'h000, 64'd0, 64'h500, 1'b0);
        exec(1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 12'h000, 64'd0, 64'h8000_0100, 1'b0);
        checks++; if (obs_redir !== 1'b1 || obs_rpc !== 64'h8000_0100) begin errors++;
            $display("FAIL b2b_redirect got %b pc=%h want 1 pc=80000100", obs_redir, obs_rpc); end
        peek(12'h342, v);
        checks++; if (v !== 64'd3) begin errors++; $display("FAIL b2b_cause got %h want 3", v); end
        peek(12'h341, v);
        checks++; if (v !== 64'h8000_0100) begin errors++; $display("FAIL b2b_mepc got %h want 80000100", v); end
    endtask

    task automatic test_reset_during_trap();
        logic [63:0] v;
        instrValid = 1'b1; exceptSignal = 3'b010; pc = 64'h6000;
        @(posedge clk); #1; idle();
        checks++; if (pcRedirect !== 1'b1) begin errors++; $display("FAIL rst_enter_pre got %b want 1", pcRedirect); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; m_reset();
        checks++; if ({pcRedirect, flush, trapStall} !== 3'b000 || privMode !== 2'b11) begin errors++;
            $display("FAIL rst_in_enter got ctrl=%b priv=%b want ctrl=000 priv=11", {pcRedirect, flush, trapStall}, privMode); end
        peek(12'h341, v);
        checks++; if (v !== 64'd0) begin errors++; $display("FAIL rst_mepc got %h want 0", v); end
        @(posedge clk); #1;
        checks++; if (pcRedirect !== 1'b0) begin errors++; $display("FAIL rst_no_redirect got %b want 0", pcRedirect); end
    endtask

    task automatic test_random();
        logic [63:0] v, op;
        logic [11:0] a;
        for (int it = 0; it < 300; it++) begin
            a  = addrs[$urandom % 8];
            op = ($urandom % 3 == 0) ? 64'd0 : {$urandom, $urandom};
            if (a == 12'h300) op = ($urandom % 4 == 0) ? 64'h1800 : (op & ~64'h1800);
            exec(($urandom % 8) != 0, ($urandom % 6 == 0) ? 3'($urandom) : 3'b000, ($urandom % 10) == 0,
                 1'($urandom), 3'($urandom), a, op, {$urandom, $urandom} & ~64'h3, 1'($urandom));
            checks++; if (obs_rdata !== exp_rdata) begin errors++;
                $display("FAIL rnd_rdata it=%0d addr=%h got %h want %h", it, a, obs_rdata, exp_rdata); end
            checks++; if ({obs_redir, obs_flush, obs_stall} !== {3{exp_redir}}) begin errors++;
                $display("FAIL rnd_ctrl it=%0d got %b want %b", it, {obs_redir, obs_flush, obs_stall}, {3{exp_redir}}); end
            if (exp_redir) begin
                checks++; if (obs_rpc !== exp_rpc) begin errors++;
                    $display("FAIL rnd_rpc it=%0d got %h want %h", it, obs_rpc, exp_rpc); end
            end
            checks++; if (obs_post !== 3'b000 || obs_priv !== m_priv) begin errors++;
                $display("FAIL rnd_post it=%0d got ctrl=%b priv=%b want ctrl=000 priv=%b", it, obs_post, obs_priv, m_priv); end
            for (int k = 0; k < 6; k++) begin
                peek(addrs[k], v);
                checks++; if (v !== m_read(addrs[k])) begin errors++;
                    $display("FAIL rnd_csr it=%0d addr=%h got %h want %h", it, addrs[k], v, m_read(addrs[k])); end
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_csr_rw();
        test_u_ecall();
        test_priority();
        test_mret();
        test_interrupt();
        test_back_to_back();
        test_reset_during_trap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
